cache_ro_fill: RTL and testbench
================================

CACHE_RO_FILL -- requirements
Module: cache_ro_fill

Interface
REQ-001 SHALL have parameter SIZE_BLOCK, default 32, meaning block width in bits.
REQ-002 SHALL have parameter BIT_TOTAL, default 24, meaning block address width.
REQ-003 SHALL have parameter BIT_INDEX, default 8, meaning set index width; tag width = BIT_TOTAL-BIT_INDEX.
REQ-004 SHALL have parameter WAY, default 2, meaning ways per set; legal range 1..8.
REQ-005 SHALL have parameter BIT_CNT, default 16, meaning statistics counter width.
REQ-006 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-007 i_rst_n  in  1  asynchronous reset, active-low.
REQ-008 i_req_valid  in  1  lookup request valid.
REQ-009 o_req_ready  out  1  block accepts request this cycle.
REQ-010 i_req_addr  in  BIT_TOTAL  requested block address.
REQ-011 o_rsp_valid  out  1  response data valid.
REQ-012 i_rsp_ready  in  1  consumer takes response.
REQ-013 o_rsp_data  out  SIZE_BLOCK  response block.
REQ-014 i_flush  in  1  invalidate-all request, single-cycle pulse.
REQ-015 o_mem_rd  out  1  backing-memory read request.
REQ-016 o_mem_addr  out  BIT_TOTAL  backing-memory block address.
REQ-017 i_mem_valid  in  1  backing-memory data valid, single-cycle pulse.
REQ-018 i_mem_data  in  SIZE_BLOCK  backing-memory data.
REQ-019 o_hits  out  BIT_CNT  saturating hit count.
REQ-020 o_misses  out  BIT_CNT  saturating miss count.

Function
REQ-021 FSM states SHALL be IDLE, LOOKUP, MISS, RESP, FLUSH.
REQ-022 o_req_ready SHALL be 1 only in IDLE with no pending flush; request is accepted when i_req_valid & o_req_ready, address is registered, and the FSM moves to LOOKUP.
REQ-023 LOOKUP SHALL compare the registered tag against all valid ways of the indexed set in one cycle.
REQ-024 On a hit, the FSM SHALL enter RESP with o_rsp_data = hit way data (o_rsp_valid first high 2 cycles after acceptance), set MRU of the set to the hit way, and increment o_hits.
REQ-025 On a miss, the FSM SHALL enter MISS and increment o_misses; in MISS, o_mem_rd = 1 and o_mem_addr = registered address, both held until i_mem_valid.
REQ-026 On i_mem_valid in MISS, the block SHALL write i_mem_data, tag and valid=1 into the victim way, set MRU to the victim, and enter RESP with o_rsp_data = i_mem_data.
REQ-027 The victim SHALL be the lowest-index invalid way; if none, the lowest-index way not equal to MRU; for WAY=1, way 0.
REQ-028 In RESP, o_rsp_valid SHALL stay 1 with stable o_rsp_data until i_rsp_ready; on i_rsp_ready the FSM SHALL return to IDLE.
REQ-029 o_rsp_valid SHALL be 0 and o_rsp_data SHALL be 0 outside RESP; o_mem_rd SHALL be 0 and o_mem_addr SHALL be 0 outside MISS.
REQ-030 i_flush in any state SHALL set a pending-flush flag; in IDLE with the flag set, the FSM SHALL enter FLUSH, which clears all valid bits and all MRU fields in one cycle, clears the flag, and returns to IDLE.
REQ-031 Flush SHALL take priority over a simultaneous request in IDLE; the request waits (o_req_ready = 0) and is accepted after FLUSH.
REQ-032 An outstanding miss or response SHALL complete normally before a pending flush executes; the fill SHALL still be written.
REQ-033 i_mem_valid outside MISS SHALL be ignored.
REQ-034 Counters SHALL saturate at 2^BIT_CNT-1 and SHALL not wrap.

Reset
REQ-035 While i_rst_n = 0: state = IDLE, all valid bits = 0, all MRU = 0, pending flush = 0, o_hits = o_misses = 0, and all outputs = 0 except o_req_ready, which SHALL also be 0.
REQ-036 Reset asserted mid-MISS or mid-RESP SHALL abandon the operation with no fill written; o_req_ready SHALL be 1 in the first cycle after release.

Verification (WAY=2, BIT_INDEX=2, BIT_TOTAL=8, SIZE_BLOCK=32, BIT_CNT=4)
REQ-037 Cold read addr 0x05, mem returns 0xDEADBEEF after 3 cycles -> o_mem_rd held 3 cycles with o_mem_addr = 0x05, o_rsp_data = 0xDEADBEEF, o_misses = 1.
REQ-038 Repeat read 0x05 -> o_rsp_valid 2 cycles after acceptance, data 0xDEADBEEF, no o_mem_rd, o_hits = 1.
REQ-039 Fill 0x01, 0x05, 0x09 (same set 1), then read 0x05 -> hit; read 0x01 -> miss (evicted as non-MRU).
REQ-040 i_flush pulsed during MISS for 0x02 -> fill completes and response returns; the FLUSH cycle follows; the next read of 0x02 misses.
REQ-041 i_rsp_ready held 0 for 4 cycles in RESP -> o_rsp_valid and o_rsp_data stable for all 4 cycles, o_req_ready = 0.
REQ-042 20 hits -> o_hits = 15; i_rst_n low mid-MISS -> counters 0 and no fill written.

Source files
------------

// File: rtl/cache_ro_fill.sv
// Read-only set-associative block cache with single-outstanding miss fill,
// MRU-based victim choice, deferred invalidate-all and saturating hit/miss counters.
module cache_ro_fill #(
    parameter int SIZE_BLOCK = 32,
    parameter int BIT_TOTAL  = 24,
    parameter int BIT_INDEX  = 8,
    parameter int WAY        = 2,
    parameter int BIT_CNT    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [BIT_TOTAL-1:0]  i_req_addr,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [SIZE_BLOCK-1:0] o_rsp_data,
    input  logic                  i_flush,
    output logic                  o_mem_rd,
    output logic [BIT_TOTAL-1:0]  o_mem_addr,
    input  logic                  i_mem_valid,
    input  logic [SIZE_BLOCK-1:0] i_mem_data,
    output logic [BIT_CNT-1:0]    o_hits,
    output logic [BIT_CNT-1:0]    o_misses
);
    localparam int BIT_TAG = BIT_TOTAL - BIT_INDEX;
    localparam int SETS    = 1 << BIT_INDEX;
    localparam int BIT_WAY = (WAY > 1) ? $clog2(WAY) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS, S_RESP, S_FLUSH} state_t;

    state_t                r_state;
    logic [BIT_TOTAL-1:0]  r_addr;
    logic                  r_flush_pend;
    logic                  r_rsp_valid;
    logic [SIZE_BLOCK-1:0] r_rsp_data;
    logic                  r_mem_rd;
    logic [BIT_TOTAL-1:0]  r_mem_addr;
    logic [BIT_CNT-1:0]    r_hits;
    logic [BIT_CNT-1:0]    r_misses;
    logic [WAY-1:0]        r_valid [SETS];
    logic [BIT_WAY-1:0]    r_mru   [SETS];
    logic [BIT_TAG-1:0]    r_tag   [SETS][WAY];
    logic [SIZE_BLOCK-1:0] r_data  [SETS][WAY];

    logic [BIT_INDEX-1:0]  w_idx;
    logic [BIT_TAG-1:0]    w_tag;
    logic                  w_hit;
    logic [BIT_WAY-1:0]    w_hit_way;
    logic [SIZE_BLOCK-1:0] w_hit_data;
    logic [BIT_WAY-1:0]    w_victim;
    logic                  w_found;
    logic                  w_accept;
    logic                  w_fill;

    assign w_idx    = r_addr[BIT_INDEX-1:0];
    assign w_tag    = r_addr[BIT_TOTAL-1:BIT_INDEX];
    assign w_fill   = (r_state == S_MISS) && i_mem_valid;

    // Gated by i_rst_n so the port is low during reset yet high in the first cycle after release.
    assign o_req_ready = i_rst_n && (r_state == S_IDLE) && !r_flush_pend && !i_flush;
    assign w_accept    = i_req_valid && o_req_ready;

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_mem_rd    = r_mem_rd;
    assign o_mem_addr  = r_mem_addr;
    assign o_hits      = r_hits;
    assign o_misses    = r_misses;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_hit_data = '0;
        for (int i = 0; i < WAY; i++) begin
            if (r_valid[w_idx][i] && (r_tag[w_idx][i] == w_tag)) begin
                w_hit      = 1'b1;
                w_hit_way  = BIT_WAY'(i);
                w_hit_data = r_data[w_idx][i];
            end
        end
    end

    // Victim: first invalid way, else first way that is not MRU, else way 0.
    always_comb begin
        w_victim = '0;
        w_found  = 1'b0;
        for (int i = 0; i < WAY; i++) begin
            if (!w_found && !r_valid[w_idx][i]) begin
                w_victim = BIT_WAY'(i);
                w_found  = 1'b1;
            end
        end
        for (int i = 0; i < WAY; i++) begin
            if (!w_found && (BIT_WAY'(i) != r_mru[w_idx])) begin
                w_victim = BIT_WAY'(i);
                w_found  = 1'b1;
            end
        end
    end

    // NOTE: tag and data arrays are not reset; the valid bits alone qualify their contents.
    always_ff @(posedge i_clk) begin
        if (w_fill) begin
            r_tag[w_idx][w_victim]  <= w_tag;
            r_data[w_idx][w_victim] <= i_mem_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_flush_pend <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= '0;
            r_hits       <= '0;
            r_misses     <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_mru[s]   <= '0;
            end
        end else begin
            if (i_flush) r_flush_pend <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (r_flush_pend) begin
                        r_state <= S_FLUSH;
                    end else if (w_accept) begin
                        r_addr  <= i_req_addr;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_data   <= w_hit_data;
                        r_mru[w_idx] <= w_hit_way;
                        if (r_hits != {BIT_CNT{1'b1}}) r_hits <= r_hits + 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= r_addr;
                        if (r_misses != {BIT_CNT{1'b1}}) r_misses <= r_misses + 1'b1;
                        r_state    <= S_MISS;
                    end
                end
                S_MISS: begin
                    if (i_mem_valid) begin
                        r_valid[w_idx][w_victim] <= 1'b1;
                        r_mru[w_idx]             <= w_victim;
                        r_mem_rd                 <= 1'b0;
                        r_mem_addr               <= '0;
                        r_rsp_valid              <= 1'b1;
                        r_rsp_data               <= i_mem_data;
                        r_state                  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_data  <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    for (int s = 0; s < SETS; s++) begin
                        r_valid[s] <= '0;
                        r_mru[s]   <= '0;
                    end
                    if (!i_flush) r_flush_pend <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ro_fill.sv
// Directed bench for cache_ro_fill (WAY=2, BIT_INDEX=2, BIT_TOTAL=8, SIZE_BLOCK=32, BIT_CNT=4):
// hand-computed fills, hits, evictions, flush ordering, stalls, saturation and reset mid-miss.
module tb_cache_ro_fill;
    logic        clk;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [7:0]  i_req_addr;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_data;
    logic        i_flush;
    logic        o_mem_rd;
    logic [7:0]  o_mem_addr;
    logic        i_mem_valid;
    logic [31:0] i_mem_data;
    logic [3:0]  o_hits;
    logic [3:0]  o_misses;

    int n_asserts = 0;
    int n_fail    = 0;
    int exp_hits  = 0;
    int exp_misses = 0;

    cache_ro_fill #(
        .SIZE_BLOCK(32), .BIT_TOTAL(8), .BIT_INDEX(2), .WAY(2), .BIT_CNT(4)
    ) dut (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
        .i_flush(i_flush),
        .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr),
        .i_mem_valid(i_mem_valid), .i_mem_data(i_mem_data),
        .o_hits(o_hits), .o_misses(o_misses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic int sat_inc(input int v);
        return (v == 15) ? 15 : v + 1;
    endfunction

    // Leaves the bench in the LOOKUP cycle (one cycle after acceptance).
    task automatic send_req(input logic [7:0] addr);
        int n;
        n = 0;
        i_req_valid = 1'b1;
        i_req_addr  = addr;
        while (!o_req_ready && n < 20) begin
            step();
            n++;
        end
        check("req_ready_wait", 32'(n < 20), 32'd1);
        step();
        i_req_valid = 1'b0;
        i_req_addr  = '0;
        check("lookup_rsp_valid", o_rsp_valid, 32'd0);
    endtask

    task automatic take_rsp();
        i_rsp_ready = 1'b1;
        step();
        i_rsp_ready = 1'b0;
        check("post_rsp_valid", o_rsp_valid, 32'd0);
        check("post_rsp_data", o_rsp_data, 32'd0);
    endtask

    task automatic read_hit(input logic [7:0] addr, input logic [31:0] data);
        send_req(addr);
        step();
        exp_hits = sat_inc(exp_hits);
        check("hit_rsp_valid", o_rsp_valid, 32'd1);
        check("hit_rsp_data", o_rsp_data, data);
        check("hit_no_mem_rd", o_mem_rd, 32'd0);
        check("hit_count", o_hits, exp_hits);
        take_rsp();
    endtask

    // Miss with memory answering in the lat-th MISS cycle; optional flush pulse in MISS cycle flush_k.
    task automatic read_miss(input logic [7:0] addr, input logic [31:0] data,
                             input int lat, input int flush_k);
        send_req(addr);
        step();
        exp_misses = sat_inc(exp_misses);
        check("miss_count", o_misses, exp_misses);
        check("miss_rsp_valid", o_rsp_valid, 32'd0);
        for (int k = 0; k < lat; k++) begin
            check("miss_mem_rd", o_mem_rd, 32'd1);
            check("miss_mem_addr", o_mem_addr, addr);
            i_flush = (k == flush_k);
            if (k == lat - 1) begin
                i_mem_valid = 1'b1;
                i_mem_data  = data;
            end
            step();
            i_flush = 1'b0;
        end
        i_mem_valid = 1'b0;
        i_mem_data  = '0;
        check("fill_rsp_valid", o_rsp_valid, 32'd1);
        check("fill_rsp_data", o_rsp_data, data);
        check("fill_mem_rd_off", o_mem_rd, 32'd0);
        check("fill_mem_addr_off", o_mem_addr, 32'd0);
        take_rsp();
    endtask

    initial begin
        i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_addr = '0; i_rsp_ready = 1'b0;
        i_flush = 1'b0; i_mem_valid = 1'b0; i_mem_data = '0;
        step();
        step();
        check("rst_req_ready", o_req_ready, 32'd0);
        check("rst_rsp_valid", o_rsp_valid, 32'd0);
        check("rst_rsp_data", o_rsp_data, 32'd0);
        check("rst_mem_rd", o_mem_rd, 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'd0);
        check("rst_hits", o_hits, 32'd0);
        check("rst_misses", o_misses, 32'd0);
        i_rst_n = 1'b1;
        #1;
        check("rel_req_ready", o_req_ready, 32'd1);

        // Cold miss, 3-cycle memory latency, then a hit on the same block.
        read_miss(8'h05, 32'hDEADBEEF, 3, -1);
        read_hit(8'h05, 32'hDEADBEEF);

        // Response held off for 4 cycles.
        send_req(8'h05);
        step();
        exp_hits = sat_inc(exp_hits);
        for (int k = 0; k < 4; k++) begin
            check("stall_rsp_valid", o_rsp_valid, 32'd1);
            check("stall_rsp_data", o_rsp_data, 32'hDEADBEEF);
            check("stall_req_ready", o_req_ready, 32'd0);
            step();
        end
        check("stall_hits", o_hits, exp_hits);
        take_rsp();

        // Flush during a miss: the fill and response finish, then FLUSH, then 0x02 misses again.
        read_miss(8'h02, 32'h22222222, 2, 0);
        check("flush_pend_ready", o_req_ready, 32'd0);
        step();
        check("flush_cycle_ready", o_req_ready, 32'd0);
        step();
        check("after_flush_ready", o_req_ready, 32'd1);
        read_miss(8'h02, 32'h2222AAAA, 1, -1);

        // Set 1 on a clean cache: 0x09 evicts 0x01 (way0, non-MRU); 0x05 stays in way1.
        read_miss(8'h01, 32'h01010101, 2, -1);
        read_miss(8'h05, 32'h05050505, 2, -1);
        read_miss(8'h09, 32'h09090909, 2, -1);
        read_hit(8'h05, 32'h05050505);
        read_miss(8'h01, 32'h0101BEEF, 2, -1);
        read_hit(8'h05, 32'h05050505);
        read_hit(8'h01, 32'h0101BEEF);

        // Flush beats a simultaneous request; the request is taken after FLUSH.
        i_req_valid = 1'b1;
        i_req_addr  = 8'h05;
        i_flush     = 1'b1;
        #1;
        check("flush_vs_req_ready", o_req_ready, 32'd0);
        step();
        i_flush = 1'b0;
        check("flush_wait_ready", o_req_ready, 32'd0);
        step();
        check("flush_state_ready", o_req_ready, 32'd0);
        step();
        check("flush_done_ready", o_req_ready, 32'd1);
        read_miss(8'h05, 32'h55AA55AA, 1, -1);

        // Stray memory data outside MISS has no effect.
        i_mem_valid = 1'b1;
        i_mem_data  = 32'hBADBAD00;
        step();
        i_mem_valid = 1'b0;
        i_mem_data  = '0;
        check("stray_rsp_valid", o_rsp_valid, 32'd0);
        check("stray_req_ready", o_req_ready, 32'd1);
        read_hit(8'h05, 32'h55AA55AA);

        // Hit counter saturates at 15.
        for (int k = 0; k < 20; k++) read_hit(8'h05, 32'h55AA55AA);
        check("hits_saturated", o_hits, 32'd15);

        // Reset mid-MISS abandons the fill and clears counters.
        send_req(8'h0D);
        step();
        check("rstmiss_mem_rd", o_mem_rd, 32'd1);
        i_rst_n = 1'b0;
        #1;
        exp_hits = 0;
        exp_misses = 0;
        check("rstmiss_hits", o_hits, 32'd0);
        check("rstmiss_misses", o_misses, 32'd0);
        check("rstmiss_mem_rd_off", o_mem_rd, 32'd0);
        check("rstmiss_req_ready", o_req_ready, 32'd0);
        i_mem_valid = 1'b1;
        i_mem_data  = 32'h0D0D0D0D;
        step();
        i_mem_valid = 1'b0;
        i_mem_data  = '0;
        step();
        i_rst_n = 1'b1;
        #1;
        check("rstmiss_rel_ready", o_req_ready, 32'd1);
        read_miss(8'h0D, 32'hD00DD00D, 2, -1);
        read_miss(8'h05, 32'h5A5A5A5A, 1, -1);
        check("final_hits", o_hits, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
